// File: rtl/pll_mode_ctrl.sv
// pll_mode_ctrl: applies divider presets to a Gowin PLL via its dynamic
// select inputs, pulses PLL reset, qualifies lock and retries on timeout.
module pll_mode_ctrl #(
    parameter int NUM_MODES    = 4,
    parameter int MODE_W       = 2,
    parameter logic [NUM_MODES*18-1:0] MODE_TABLE = {
        6'd1, 6'd9,  6'd8,
        6'd0, 6'd4,  6'd8,
        6'd2, 6'd19, 6'd4,
        6'd2, 6'd24, 6'd4
    },
    parameter int DEFAULT_MODE = 0,
    parameter int RST_CYCLES   = 24,
    parameter int LOCK_STABLE  = 64,
    parameter int LOCK_TIMEOUT = 24000,
    parameter int MAX_RETRY    = 3
) (
    input  logic              clkin,
    input  logic              resetn,
    input  logic              pll_lock,
    input  logic              mode_req,
    input  logic [MODE_W-1:0] mode_sel,
    output logic              pll_reset,
    output logic [5:0]        idsel,
    output logic [5:0]        fbdsel,
    output logic [5:0]        odsel,
    output logic              clk_en,
    output logic              locked,
    output logic              busy,
    output logic              mode_done,
    output logic              mode_err,
    output logic              fail,
    output logic [MODE_W-1:0] cur_mode,
    output logic [7:0]        loss_cnt
);

    localparam int RST_W = $clog2(RST_CYCLES + 1);
    localparam int STB_W = $clog2(LOCK_STABLE + 1);
    localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int RT_W  = $clog2(MAX_RETRY + 1);
    localparam logic [MODE_W:0] NM = NUM_MODES[MODE_W:0];
    localparam logic [17:0] DEF_ENT = MODE_TABLE[18*DEFAULT_MODE +: 18];

    typedef enum logic [1:0] {APPLY, WAIT_LOCK, RUN, FAIL} state_t;

    state_t            state, state_nx;
    logic [RST_W-1:0]  rst_cnt, rst_cnt_nx;
    logic [STB_W-1:0]  stb_cnt, stb_nx;
    logic [TO_W-1:0]   to_cnt, to_nx;
    logic [RT_W-1:0]   retry, retry_nx;
    logic [MODE_W-1:0] mode_nx;
    logic [17:0]       sel, sel_nx;
    logic              pll_reset_nx, clk_en_nx, busy_nx, fail_nx;
    logic              done_nx, err_nx;
    logic [7:0]        loss_nx;
    logic              lock_s1, lock_sync;
    logic              go_apply;

    function automatic logic [17:0] entry(input logic [MODE_W-1:0] m);
        return MODE_TABLE[18*int'(m) +: 18];
    endfunction

    assign idsel  = sel[17:12];
    assign fbdsel = sel[11:6];
    assign odsel  = sel[5:0];
    assign locked = clk_en;

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            lock_s1   <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_s1   <= pll_lock;
            lock_sync <= lock_s1;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state     <= APPLY;
            rst_cnt   <= '0;
            stb_cnt   <= '0;
            to_cnt    <= '0;
            retry     <= '0;
            cur_mode  <= MODE_W'(DEFAULT_MODE);
            sel       <= DEF_ENT;
            pll_reset <= 1'b1;
            clk_en    <= 1'b0;
            busy      <= 1'b1;
            fail      <= 1'b0;
            mode_done <= 1'b0;
            mode_err  <= 1'b0;
            loss_cnt  <= 8'd0;
        end else begin
            state     <= state_nx;
            rst_cnt   <= rst_cnt_nx;
            stb_cnt   <= stb_nx;
            to_cnt    <= to_nx;
            retry     <= retry_nx;
            cur_mode  <= mode_nx;
            sel       <= sel_nx;
            pll_reset <= pll_reset_nx;
            clk_en    <= clk_en_nx;
            busy      <= busy_nx;
            fail      <= fail_nx;
            mode_done <= done_nx;
            mode_err  <= err_nx;
            loss_cnt  <= loss_nx;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nx     = state;
        rst_cnt_nx   = rst_cnt;
        stb_nx       = stb_cnt;
        to_nx        = to_cnt;
        retry_nx     = retry;
        mode_nx      = cur_mode;
        sel_nx       = sel;
        pll_reset_nx = pll_reset;
        clk_en_nx    = clk_en;
        busy_nx      = busy;
        fail_nx      = fail;
        done_nx      = 1'b0;
        err_nx       = 1'b0;
        loss_nx      = loss_cnt;
        go_apply     = 1'b0;

        unique case (state)
            APPLY: begin
                if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
                    state_nx     = WAIT_LOCK;
                    pll_reset_nx = 1'b0;
                    stb_nx       = '0;
                    to_nx        = '0;
                end else begin
                    rst_cnt_nx = rst_cnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                to_nx  = to_cnt + 1'b1;
                stb_nx = lock_sync ? stb_cnt + 1'b1 : '0;
                if (stb_nx == STB_W'(LOCK_STABLE)) begin
                    state_nx  = RUN;
                    clk_en_nx = 1'b1;
                    busy_nx   = 1'b0;
                    done_nx   = 1'b1;
                    retry_nx  = '0;
                end else if (to_nx == TO_W'(LOCK_TIMEOUT)) begin
                    retry_nx = retry + 1'b1;
                    if (retry_nx < RT_W'(MAX_RETRY)) begin
                        go_apply = 1'b1;
                    end else begin
                        state_nx = FAIL;
                        fail_nx  = 1'b1;
                        busy_nx  = 1'b0;
                    end
                end
            end
            RUN: begin
                if (!lock_sync) begin
                    loss_nx  = (loss_cnt == 8'hFF) ? loss_cnt
                                                   : loss_cnt + 8'd1;
                    retry_nx = '0;
                    go_apply = 1'b1;
                end
            end
            FAIL: begin
            end
        endcase

        // Requests are only honoured when idle (RUN or FAIL)
        if ((state == RUN || state == FAIL) && mode_req) begin
            if ({1'b0, mode_sel} < NM) begin
                mode_nx  = mode_sel;
                retry_nx = '0;
                go_apply = 1'b1;
            end else begin
                err_nx = 1'b1;
            end
        end

        if (go_apply) begin
            state_nx     = APPLY;
            rst_cnt_nx   = '0;
            pll_reset_nx = 1'b1;
            busy_nx      = 1'b1;
            clk_en_nx    = 1'b0;
            fail_nx      = 1'b0;
            sel_nx       = entry(mode_nx);
        end
    end

endmodule

// File: tb/tb_pll_mode_ctrl.sv
// tb_pll_mode_ctrl: scoreboard bench for pll_mode_ctrl.
// Expected {mode,selects} queued per request, checked on mode_done.
module tb_pll_mode_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pll_lock;
    logic       mode_req;
    logic [2:0] mode_sel;
    logic       pll_reset;
    logic [5:0] idsel, fbdsel, odsel;
    logic       clk_en, locked, busy, mode_done, mode_err, fail;
    logic [2:0] cur_mode;
    logic [7:0] loss_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [20:0] sb_q[$];

    always #5 clk = ~clk;

    pll_mode_ctrl #(
        .NUM_MODES(4),
        .MODE_W(3),
        .DEFAULT_MODE(0),
        .RST_CYCLES(4),
        .LOCK_STABLE(8),
        .LOCK_TIMEOUT(100),
        .MAX_RETRY(2)
    ) dut (
        .clkin(clk),
        .resetn(resetn),
        .pll_lock(pll_lock),
        .mode_req(mode_req),
        .mode_sel(mode_sel),
        .pll_reset(pll_reset),
        .idsel(idsel),
        .fbdsel(fbdsel),
        .odsel(odsel),
        .clk_en(clk_en),
        .locked(locked),
        .busy(busy),
        .mode_done(mode_done),
        .mode_err(mode_err),
        .fail(fail),
        .cur_mode(cur_mode),
        .loss_cnt(loss_cnt)
    );

    function automatic logic [17:0] ent(input int m);
        case (m)
            0:       return {6'd2, 6'd24, 6'd4};
            1:       return {6'd2, 6'd19, 6'd4};
            2:       return {6'd0, 6'd4,  6'd8};
            default: return {6'd1, 6'd9,  6'd8};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int m);
        sb_q.push_back({3'(m), ent(m)});
    endtask

    task automatic rst_len(output int n);
        n = 0;
        while (pll_reset && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (!clk_en && n < 1000) begin
            tick();
            n++;
        end
        chk("run_reached", clk_en, 1);
    endtask

    task automatic request(input int m);
        mode_sel = 3'(m);
        mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
    endtask

    // Scoreboard: every mode_done consumes one expected entry
    always @(negedge clk) begin
        if (resetn && mode_done) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_done", 1, 0);
            end else begin
                logic [20:0] e;
                e = sb_q.pop_front();
                chk("done_mode", cur_mode, e[20:18]);
                chk("done_sel", {idsel, fbdsel, odsel}, e[17:0]);
                chk("done_clk_en", clk_en, 1);
            end
        end
    end

    initial begin
        int n, w, rises, ens, exp_loss;
        logic prev;

        resetn   = 1'b0;
        pll_lock = 1'b1;
        mode_req = 1'b0;
        mode_sel = 3'd0;
        repeat (3) tick();

        // Reset values
        chk("rst_pll_reset", pll_reset, 1);
        chk("rst_busy", busy, 1);
        chk("rst_clk_en", clk_en, 0);
        chk("rst_locked", locked, 0);
        chk("rst_fail", fail, 0);
        chk("rst_mode", cur_mode, 0);
        chk("rst_sel", {idsel, fbdsel, odsel}, ent(0));
        chk("rst_loss", loss_cnt, 0);
        push(0);
        resetn = 1'b1;

        // Power-up apply of the default mode
        rst_len(n);
        chk("pwrup_rst_len", n, 4);
        wait_run(n);
        chk("pwrup_lock_cycles", n, 8);
        chk("pwrup_busy", busy, 0);
        chk("pwrup_done", mode_done, 1);
        chk("pwrup_locked", locked, 1);

        // Switch to mode 3
        push(3);
        request(3);
        chk("req3_clk_en", clk_en, 0);
        chk("req3_mode", cur_mode, 3);
        chk("req3_sel", {idsel, fbdsel, odsel}, ent(3));
        chk("req3_busy", busy, 1);
        rst_len(n);
        chk("req3_rst_len", n, 4);
        wait_run(n);
        chk("req3_lock_cycles", n, 8);

        // Lock never arrives: two timed-out applies, then fail
        pll_lock = 1'b0;
        n = 0; w = 0; rises = 0; prev = pll_reset;
        while (!fail && n < 1000) begin
            tick();
            n++;
            if (busy && !pll_reset) w++;
            if (pll_reset && !prev) rises++;
            prev = pll_reset;
        end
        chk("to_fail", fail, 1);
        chk("to_wait_cycles", w, 200);
        chk("to_applies", rises, 2);
        chk("to_busy", busy, 0);
        chk("to_pll_reset", pll_reset, 0);
        chk("to_clk_en", clk_en, 0);
        chk("to_loss", loss_cnt, 1);
        tick();
        chk("to_fail_held", fail, 1);

        // Recovery from fail by requesting mode 1
        pll_lock = 1'b1;
        push(1);
        request(1);
        chk("rec_fail", fail, 0);
        chk("rec_busy", busy, 1);
        chk("rec_pll_reset", pll_reset, 1);
        chk("rec_sel", {idsel, fbdsel, odsel}, ent(1));
        wait_run(n);

        // Lock chatter (7 high, 1 low) never qualifies
        push(2);
        request(2);
        rises = 0; ens = 0; prev = pll_reset;
        for (int i = 0; i < 152; i++) begin
            pll_lock = (i % 8 != 7);
            tick();
            if (pll_reset && !prev) rises++;
            if (clk_en) ens++;
            prev = pll_reset;
        end
        chk("chat_no_run", ens, 0);
        chk("chat_retry_apply", rises, 1);
        chk("chat_busy", busy, 1);
        pll_lock = 1'b0;
        repeat (2) tick();
        pll_lock = 1'b1;
        wait_run(n);
        chk("chat_lock_cycles", n, 10);

        // Repeated single-cycle lock loss, saturating counter
        exp_loss = 1;
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b0;
            tick();
            pll_lock = 1'b1;
            n = 0;
            while (clk_en && n < 10) begin
                tick();
                n++;
            end
            chk("loss_clk_en", clk_en, 0);
            exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
            chk("loss_cnt", loss_cnt, exp_loss);
            push(2);
            wait_run(n);
        end
        chk("loss_sat", loss_cnt, 255);

        // Out-of-range request
        request(5);
        chk("err_pulse", mode_err, 1);
        chk("err_clk_en", clk_en, 1);
        chk("err_mode", cur_mode, 2);
        chk("err_busy", busy, 0);
        chk("err_sel", {idsel, fbdsel, odsel}, ent(2));
        tick();
        chk("err_one_cycle", mode_err, 0);

        // Request while busy is dropped
        push(1);
        request(1);
        request(3);
        chk("busy_ign_mode", cur_mode, 1);
        chk("busy_ign_sel", {idsel, fbdsel, odsel}, ent(1));
        rst_len(n);
        tick();
        chk("mid_in_wait", busy && !pll_reset, 1);

        // Reset in WAIT_LOCK
        resetn = 1'b0;
        #1;
        chk("mid_rst_pll_reset", pll_reset, 1);
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_mode", cur_mode, 0);
        chk("mid_rst_sel", {idsel, fbdsel, odsel}, ent(0));
        chk("mid_rst_loss", loss_cnt, 0);
        chk("mid_rst_clk_en", clk_en, 0);
        sb_q.delete();
        push(0);
        repeat (2) tick();
        resetn = 1'b1;
        rst_len(n);
        chk("mid_rst_len", n, 4);
        wait_run(n);
        chk("mid_lock_cycles", n, 8);
        chk("mid_run_mode", cur_mode, 0);
        repeat (2) tick();

        chk("sb_left", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_mode_ctrl.md
Name: pll_mode_ctrl

Overview:
- Sequencing controller for a Gowin PLL whose dividers are driven through its dynamic select inputs (IDSEL/FBDSEL/ODSEL).
- Holds a table of divider presets and applies the selected one by pulsing the PLL reset.
- Qualifies the PLL lock and retries on timeout.
- Gates downstream logic (e.g. LCD timing) via clk_en. Runs on the crystal input clock, beside the PLL instance.

Parameters:
NUM_MODES, 4, number of preset entries (1..16)
MODE_W, 2, width of mode_sel/cur_mode; must satisfy 2**MODE_W >= NUM_MODES
MODE_TABLE, 4 entries {idsel,fbdsel,odsel}: m0={2,24,4} m1={2,19,4} m2={0,4,8} m3={1,9,8}, packed NUM_MODES*18 bits; entry i at [18*i+17:18*i] = {idsel[5:0],fbdsel[5:0],odsel[5:0]}; codes passed to PLL unmodified
DEFAULT_MODE, 0, mode applied after reset
RST_CYCLES, 24, clkin cycles pll_reset is held per apply (>=1)
LOCK_STABLE, 64, consecutive synchronised-lock cycles required to declare lock (>=1)
LOCK_TIMEOUT, 24000, cycles allowed in WAIT_LOCK before a retry
MAX_RETRY, 3, applies per request before FAIL (>=1)

Ports:
clkin  in  1  controller clock (crystal)
resetn  in  1  asynchronous active-low reset
pll_lock  in  1  PLL LOCK; asynchronous, 2-flop synchronised internally
mode_req  in  1  request to apply mode_sel; sampled only when busy=0
mode_sel  in  MODE_W  requested mode index
pll_reset  out  1  to PLL RESET
idsel, fbdsel, odsel  out  6 each  to PLL IDSEL/FBDSEL/ODSEL
clk_en  out  1  downstream enable; high only in RUN
locked  out  1  qualified lock; equals clk_en
busy  out  1  high in APPLY and WAIT_LOCK
mode_done  out  1  1-cycle pulse on every entry to RUN
mode_err  out  1  1-cycle pulse on an out-of-range request
fail  out  1  high in FAIL
cur_mode  out  MODE_W  mode being applied or running
loss_cnt  out  8  saturating count of lock losses in RUN

Behaviour:
- All outputs registered. Async reset values:
  - pll_reset=1, busy=1, selects=table[DEFAULT_MODE], cur_mode=DEFAULT_MODE.
  - clk_en=locked=fail=mode_done=mode_err=0, loss_cnt=0, retry=0.
  - State APPLY, counters 0.
- APPLY:
  - Selects driven from table[cur_mode]; pll_reset=1 for exactly RST_CYCLES cycles.
  - Then pll_reset=0 and go WAIT_LOCK. Timeout and stable counters cleared.
- WAIT_LOCK:
  - Timeout counter increments every cycle.
  - Stable counter increments while lock_sync=1 and clears to 0 on any lock_sync=0.
  - Stable counter reaching LOCK_STABLE -> RUN, retry=0. If this coincides with timeout, lock wins.
  - Timeout reaching LOCK_TIMEOUT -> retry+1. If retry+1 < MAX_RETRY, go APPLY (same mode); else FAIL.
- RUN:
  - clk_en=locked=1; mode_done pulses in the first RUN cycle.
  - lock_sync=0 for any single cycle -> next cycle clk_en=locked=0, loss_cnt+1 (saturate at 255), retry=0, go APPLY with same mode.
- FAIL: fail=1, pll_reset=0, clk_en=0. Leaves only on an accepted request.
- Request handshake (RUN or FAIL only):
  - mode_req=1 with mode_sel<NUM_MODES -> cur_mode=mode_sel, retry=0, fail=0, clk_en=0 on the next cycle, go APPLY.
  - mode_sel>=NUM_MODES -> mode_err pulse, state unchanged.
  - mode_req while busy=1 is ignored; no queuing.
  - In RUN, a simultaneous request and lock loss: request wins, and loss_cnt still increments.
- Requesting the current mode is legal and re-applies it.
- Selects change only on entry to APPLY, never while pll_reset=0.
- resetn asserted mid-sequence returns everything to reset values immediately. Release restarts APPLY with DEFAULT_MODE.

Test Plan:
(bench params: RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=100, MAX_RETRY=2)
- Reset release, pll_lock tied 1 -> pll_reset high exactly 4 cycles, selects={2,24,4}; clk_en rises at 8 stable cycles after sync; one mode_done; busy falls with clk_en rise.
- In RUN, mode_sel=3 with 1-cycle mode_req -> clk_en low next cycle, selects={1,9,8}, cur_mode=3, pll_reset 4 cycles, relock, mode_done.
- pll_lock held 0 -> two applies of 100 WAIT_LOCK cycles each, then fail=1, busy=0, pll_reset=0. Request mode 1 -> fail clears, apply proceeds.
- pll_lock toggles 1 for 7 cycles then 0 repeatedly -> no RUN entry; timeout path taken. Then hold 1 -> lock in 8 cycles.
- In RUN, drop pll_lock one cycle -> clk_en falls, loss_cnt=1, re-apply same mode. Repeat 300 times -> loss_cnt saturates at 255.
- mode_sel=5 with NUM_MODES=4, MODE_W=3 -> mode_err pulse, state and outputs unchanged. A request during busy is ignored. resetn pulsed low in WAIT_LOCK -> reset values, restart from DEFAULT_MODE.
